// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control with prioritised redirects,
// trap vectoring, misaligned-target detection and registered flush pulses.
module pc_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        trap,
   input  logic        halt,
   input  logic        resume,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic        flush,
   output logic [31:0] epc,
   output logic        misaligned
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic        flush_q, flush_d;
   logic        mis_q, mis_d;

   logic        redirect;
   logic [31:0] redir_target;
   logic [31:0] pc_inc;

   assign pc_inc       = pc_q + 32'd4;
   // jump outranks branch, so its target wins when both are requested
   assign redirect     = jump | branch_taken;
   assign redir_target = jump ? jump_target : branch_target;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epc_d   = epc_q;
      flush_d = 1'b0;
      mis_d   = 1'b0;
      unique case (state_q)
         S_BOOT: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (trap) begin
               epc_d   = pc_q;
               pc_d    = TRAP_VEC;
               flush_d = 1'b1;
            end else if (!stall) begin
               if (redirect) begin
                  flush_d = 1'b1;
                  if (redir_target[1:0] != 2'b00) begin
                     epc_d = pc_q;
                     pc_d  = TRAP_VEC;
                     mis_d = 1'b1;
                  end else begin
                     pc_d = redir_target;
                  end
               end else if (halt) begin
                  pc_d    = pc_inc;
                  state_d = S_HALT;
               end else begin
                  pc_d = pc_inc;
               end
            end
         end
         S_HALT: begin
            if (trap) begin
               epc_d   = pc_q;
               pc_d    = TRAP_VEC;
               flush_d = 1'b1;
               state_d = S_RUN;
            end else if (resume) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_VEC;
         epc_q   <= '0;
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         flush_q <= flush_d;
         mis_q   <= mis_d;
      end
   end

   assign pc          = pc_q;
   assign pc_plus4    = pc_inc;
   assign fetch_valid = (state_q == S_RUN);
   assign flush       = flush_q;
   assign epc         = epc_q;
   assign misaligned  = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: one table applied cycle by cycle,
// followed by a reset-under-stall sequence with a bounded wait.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst, stall, branch_taken, jump, trap, halt, resume;
   logic [31:0] branch_target, jump_target;
   logic [31:0] pc, pc_plus4, epc;
   logic        fetch_valid, flush, misaligned;

   int unsigned checks = 0;
   int unsigned errors = 0;

   pc_sequencer #(
      .RESET_VEC(32'h0000_0000),
      .TRAP_VEC (32'h0000_0080)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .trap         (trap),
      .halt         (halt),
      .resume       (resume),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .fetch_valid  (fetch_valid),
      .flush        (flush),
      .epc          (epc),
      .misaligned   (misaligned)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        jmp;
      logic [31:0] jt;
      logic        br;
      logic [31:0] bt;
      logic        trap;
      logic        halt;
      logic        resume;
      logic [31:0] e_pc;
      logic        e_fv;
      logic        e_fl;
      logic        e_mis;
      logic [31:0] e_epc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic s, input logic j, input logic [31:0] jt,
                      input logic b, input logic [31:0] bt, input logic t, input logic h,
                      input logic rs, input logic [31:0] e_pc, input logic e_fv,
                      input logic e_fl, input logic e_mis, input logic [31:0] e_epc);
      vec_t v;
      v.rst = r; v.stall = s; v.jmp = j; v.jt = jt; v.br = b; v.bt = bt;
      v.trap = t; v.halt = h; v.resume = rs;
      v.e_pc = e_pc; v.e_fv = e_fv; v.e_fl = e_fl; v.e_mis = e_mis; v.e_epc = e_epc;
      vecs.push_back(v);
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      rst = 1'b0; stall = 1'b0; jump = 1'b0; jump_target = '0;
      branch_taken = 1'b0; branch_target = '0; trap = 1'b0; halt = 1'b0; resume = 1'b0;
   endtask

   initial begin
      bit found;
      int unsigned waited;

      //   rst s  j  jt            b  bt          t  h  rs  pc            fv fl mis epc
      add(1, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0,  32'h0,        0, 0, 0, 32'h0);   // reset -> BOOT
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0,  32'h0,        1, 0, 0, 32'h0);   // first RUN cycle
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0,  32'h4,        1, 0, 0, 32'h0);
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0,  32'h8,        1, 0, 0, 32'h0);
      add(0, 0, 1, 32'h10,       0, 32'h0,     0, 0, 0,  32'h10,       1, 1, 0, 32'h0);
      add(0, 0, 1, 32'h200,      1, 32'h300,   0, 0, 0,  32'h200,      1, 1, 0, 32'h0);   // jump beats branch
      add(0, 0, 0, 32'h0,        1, 32'h40,    0, 0, 0,  32'h40,       1, 1, 0, 32'h0);
      add(0, 1, 0, 32'h0,        1, 32'h80,    0, 0, 0,  32'h40,       1, 0, 0, 32'h0);   // stalled x3
      add(0, 1, 0, 32'h0,        1, 32'h80,    0, 0, 0,  32'h40,       1, 0, 0, 32'h0);
      add(0, 1, 0, 32'h0,        1, 32'h80,    0, 0, 0,  32'h40,       1, 0, 0, 32'h0);
      add(0, 0, 0, 32'h0,        1, 32'h80,    0, 0, 0,  32'h80,       1, 1, 0, 32'h0);
      add(0, 0, 1, 32'h20,       0, 32'h0,     0, 0, 0,  32'h20,       1, 1, 0, 32'h0);
      add(0, 0, 0, 32'h0,        1, 32'h102,   0, 0, 0,  32'h80,       1, 1, 1, 32'h20);  // misaligned branch
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0,  32'h84,       1, 0, 0, 32'h20);
      add(0, 0, 1, 32'h30,       0, 32'h0,     0, 0, 0,  32'h30,       1, 1, 0, 32'h20);
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 1, 0,  32'h34,       0, 0, 0, 32'h20);  // halt
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0,  32'h34,       0, 0, 0, 32'h20);
      add(0, 0, 1, 32'h500,      0, 32'h0,     0, 0, 0,  32'h34,       0, 0, 0, 32'h20);
      add(0, 1, 0, 32'h0,        1, 32'h600,   0, 0, 0,  32'h34,       0, 0, 0, 32'h20);
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 1, 0,  32'h34,       0, 0, 0, 32'h20);
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 0, 1,  32'h34,       1, 0, 0, 32'h20);  // resume
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0,  32'h38,       1, 0, 0, 32'h20);
      add(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,    0, 0, 0,  32'hFFFF_FFFC, 1, 1, 0, 32'h20);
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0,  32'h0,        1, 0, 0, 32'h20);  // wrap
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0,  32'h4,        1, 0, 0, 32'h20);
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0,  32'h8,        1, 0, 0, 32'h20);
      add(0, 1, 0, 32'h0,        0, 32'h0,     1, 0, 0,  32'h80,       1, 1, 0, 32'h8);   // trap over stall
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 1, 0,  32'h84,       0, 0, 0, 32'h8);
      add(0, 0, 0, 32'h0,        0, 32'h0,     1, 0, 1,  32'h80,       1, 1, 0, 32'h84);  // trap over resume
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 1, 0,  32'h84,       0, 0, 0, 32'h84);
      add(1, 0, 1, 32'h400,      0, 32'h0,     0, 0, 0,  32'h0,        0, 0, 0, 32'h0);   // reset in HALT
      add(0, 0, 1, 32'h400,      0, 32'h0,     1, 0, 0,  32'h0,        1, 0, 0, 32'h0);   // BOOT ignores inputs
      add(0, 0, 0, 32'h0,        0, 32'h0,     0, 0, 0,  32'h4,        1, 0, 0, 32'h0);
      add(0, 0, 1, 32'h3,        0, 32'h0,     0, 0, 0,  32'h80,       1, 1, 1, 32'h4);   // misaligned jump
      add(0, 0, 1, 32'h200,      0, 32'h0,     1, 0, 0,  32'h80,       1, 1, 0, 32'h80);  // trap beats jump

      idle_inputs();
      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; stall = vecs[i].stall;
         jump = vecs[i].jmp; jump_target = vecs[i].jt;
         branch_taken = vecs[i].br; branch_target = vecs[i].bt;
         trap = vecs[i].trap; halt = vecs[i].halt; resume = vecs[i].resume;
         @(posedge clk);
         #1;
         chk32($sformatf("v%0d.pc", i), pc, vecs[i].e_pc);
         chk32($sformatf("v%0d.pc_plus4", i), pc_plus4, vecs[i].e_pc + 32'd4);
         chk1($sformatf("v%0d.fetch_valid", i), fetch_valid, vecs[i].e_fv);
         chk1($sformatf("v%0d.flush", i), flush, vecs[i].e_fl);
         chk1($sformatf("v%0d.misaligned", i), misaligned, vecs[i].e_mis);
         chk32($sformatf("v%0d.epc", i), epc, vecs[i].e_epc);
      end

      // Reset held two cycles while stalled and redirecting, then released under stall.
      idle_inputs();
      rst = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0700;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk32($sformatf("rst%0d.pc", k), pc, 32'h0);
         chk1($sformatf("rst%0d.fetch_valid", k), fetch_valid, 1'b0);
         chk1($sformatf("rst%0d.flush", k), flush, 1'b0);
         chk32($sformatf("rst%0d.epc", k), epc, 32'h0);
      end
      rst = 1'b0;
      found = 1'b0;
      waited = 0;
      while (!found && waited < 4) begin
         @(posedge clk);
         #1;
         waited++;
         if (fetch_valid) found = 1'b1;
      end
      chk1("boot_exit_seen", found, 1'b1);
      chk32("boot_exit_cycles", waited, 32'd1);
      chk32("first_run.pc", pc, 32'h0);
      chk1("first_run.flush", flush, 1'b0);
      @(posedge clk);
      #1;
      chk32("stall_after_boot.pc", pc, 32'h0);
      idle_inputs();
      @(posedge clk);
      #1;
      chk32("released.pc", pc, 32'h4);
      chk1("released.flush", flush, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- RESET_VEC, 32'h0000_0000, PC loaded by reset.
- TRAP_VEC, 32'h0000_0080, PC loaded on trap or misaligned redirect.

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on its rising edge.
- rst, in, 1, synchronous active-high reset.
- stall, in, 1, hazard hold: freeze PC and state.
- branch_taken, in, 1, take branch_target this cycle.
- branch_target, in, 32, branch destination.
- jump, in, 1, take jump_target this cycle.
- jump_target, in, 32, jump / jump-register destination.
- trap, in, 1, exception request.
- halt, in, 1, halt instruction decoded.
- resume, in, 1, leave HALT.
- pc, out, 32, current fetch address (registered).
- pc_plus4, out, 32, combinational pc+4, modulo 2^32.
- fetch_valid, out, 1, pc is a valid fetch this cycle.
- flush, out, 1, one-cycle pulse after any redirect; kills younger instructions.
- epc, out, 32, pc captured at the last trap or misaligned redirect.
- misaligned, out, 1, one-cycle pulse: the last redirect target had [1:0] != 0.

Function
REQ-003 The block SHALL implement a three-state FSM: BOOT, RUN and HALT.
REQ-004 BOOT SHALL last exactly one cycle, then go to RUN; fetch_valid=0 in BOOT and all inputs are ignored.
REQ-005 In RUN, the next pc SHALL be chosen by fixed priority: trap, then jump, then branch_taken, then halt, then sequential (pc+4).
REQ-006 Trap (RUN or HALT) SHALL set epc<=pc, pc<=TRAP_VEC, state<=RUN and flush=1 next cycle; trap overrides stall.
REQ-007 Jump or branch, with stall=0, SHALL load pc<=target and assert flush=1 next cycle.
REQ-008 A jump or branch target with target[1:0]!=0 SHALL instead load pc<=TRAP_VEC and epc<=pc, and assert flush=1 and misaligned=1 next cycle.
REQ-009 With stall=1 and no trap, pc, state, epc SHALL hold; jump, branch and halt are ignored (upstream re-presents them); flush=0 and misaligned=0.
REQ-010 Halt, with no higher-priority event and stall=0, SHALL load pc<=pc+4 and state<=HALT.
REQ-011 In HALT, fetch_valid=0, pc holds, and jump, branch, halt and stall are ignored.
REQ-012 In HALT, resume SHALL return the block to RUN with pc unchanged; trap takes priority over resume.
REQ-013 fetch_valid SHALL be 1 exactly when state=RUN.
REQ-014 Sequential increment SHALL wrap: pc=32'hFFFF_FFFC advances to 32'h0000_0000 without a flag.
REQ-015 flush and misaligned SHALL be registered single-cycle pulses; back-to-back redirects produce back-to-back pulses.
REQ-016 pc_plus4 SHALL equal pc+32'd4 (low 32 bits) in every state.

Reset
REQ-017 rst=1 at a clock edge SHALL force state=BOOT, pc=RESET_VEC, epc=0, flush=0, misaligned=0 and fetch_valid=0, regardless of any other input.
REQ-018 Reset SHALL abort any in-progress halt, stall or redirect; the first RUN cycle after reset has pc=RESET_VEC.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset then 3 free cycles -> pc sequence 0 (BOOT, fetch_valid=0), 0, 4, 8 with fetch_valid=1.
- In RUN at pc=0x10: jump=1, jump_target=0x200 and branch_taken=1, branch_target=0x300 together -> pc=0x200 and flush=1 next cycle.
- stall=1 for 3 cycles at pc=0x40 with branch_taken=1 -> pc stays 0x40 and flush=0; then stall=0 with branch_taken=1, target 0x80 -> pc=0x80.
- branch to 0x102 at pc=0x20 -> pc=0x80, epc=0x20, misaligned=1 and flush=1 for one cycle.
- halt at pc=0x30 -> pc=0x34 and fetch_valid=0 for 5 cycles; then resume -> fetch_valid=1 with pc=0x34, then 0x38.
- pc=0xFFFF_FFFC sequential -> pc=0; trap and stall together at pc=0x8 -> pc=0x80 and epc=0x8; rst asserted in HALT -> BOOT with pc=0.
